// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: request record, result-source select, default widths.
package wb_pkg;

    localparam int unsigned WL = 32;
    localparam int unsigned AL = 5;

    typedef struct packed {
        logic [AL-1:0] rd;
        logic [WL-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular load-result buffer with occupancy count and a per-entry view for hazard compare.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type req_t = wb_req_t,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  req_t                 push_data_i,
    input  logic                 pop_i,
    output req_t                 head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CW-1:0]        count_o,
    output req_t [DEPTH-1:0]     ent_o,
    output logic [DEPTH-1:0]     ent_vld_o
);

    req_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (pop_i) begin
            rd_ptr_d         = ptr_inc(rd_ptr_q);
            vld_d[rd_ptr_q]  = 1'b0;
        end
        if (push_i) begin
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            vld_d[wr_ptr_q]  = 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign ent_o     = mem_q;
    assign ent_vld_o = vld_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and buffered load results into the single register-file write port.
// Optional stall counter built when WB_PERF_EN is defined.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = WL,
    parameter int unsigned ADDR_LENGTH = AL,
    parameter int unsigned LOAD_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_LENGTH-1:0] alu_rd,
    input  logic [WORD_LENGTH-1:0] alu_result,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [ADDR_LENGTH-1:0] ld_rd,
    input  logic [WORD_LENGTH-1:0] ld_data,
    output logic                   we3,
    output logic [ADDR_LENGTH-1:0] wa3,
    output logic [WORD_LENGTH-1:0] wd3,
    input  logic [ADDR_LENGTH-1:0] qa1,
    input  logic [ADDR_LENGTH-1:0] qa2,
    output logic                   hz1,
    output logic                   hz2,
    output logic [31:0]            perf_stall
);

    localparam int unsigned CW = $clog2(LOAD_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_LENGTH-1:0] rd;
        logic [WORD_LENGTH-1:0] data;
    } req_t;

    req_t                  head, push_req;
    req_t [LOAD_DEPTH-1:0] ent;
    logic [LOAD_DEPTH-1:0] ent_vld;
    logic                  fifo_full, fifo_empty, push, pop;
    logic [CW-1:0]         fifo_count;
    wb_src_t               src;

    logic                   we3_q, we3_d;
    logic [ADDR_LENGTH-1:0] wa3_q, wa3_d;
    logic [WORD_LENGTH-1:0] wd3_q, wd3_d;

    assign ld_ready  = (fifo_count < CW'(LOAD_DEPTH));
    assign alu_ready = (fifo_count != CW'(LOAD_DEPTH));
    assign push      = ld_valid && ld_ready;
    assign pop       = (src == WB_LOAD);
    assign push_req  = '{rd: ld_rd, data: ld_data};

    wb_fifo #(
        .DEPTH (LOAD_DEPTH),
        .req_t (req_t)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .push_i      (push),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .ent_o       (ent),
        .ent_vld_o   (ent_vld)
    );

    // A full FIFO takes priority so a blocked load unit can never starve.
    always_comb begin
        src = WB_NONE;
        if (fifo_full)        src = WB_LOAD;
        else if (alu_valid)   src = WB_ALU;
        else if (!fifo_empty) src = WB_LOAD;
    end

    always_comb begin
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        case (src)
            WB_ALU: begin
                wa3_d = alu_rd;
                wd3_d = alu_result;
                we3_d = (alu_rd != '0);
            end
            WB_LOAD: begin
                wa3_d = head.rd;
                wd3_d = head.data;
                we3_d = (head.rd != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
        end
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        for (int unsigned i = 0; i < LOAD_DEPTH; i++) begin
            if (ent_vld[i] && (ent[i].rd == qa1)) hz1 = 1'b1;
            if (ent_vld[i] && (ent[i].rd == qa2)) hz2 = 1'b1;
        end
        if (we3_q && (wa3_q == qa1)) hz1 = 1'b1;
        if (we3_q && (wa3_q == qa2)) hz2 = 1'b1;
        if (qa1 == '0) hz1 = 1'b0;
        if (qa2 == '0) hz2 = 1'b0;
    end

`ifdef WB_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_q <= '0;
        else if (alu_valid && !alu_ready && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end

    assign perf_stall = stall_q;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  qa1, qa2;
    logic        hz1, hz2;
    logic [31:0] perf_stall;

    writeback_arbiter #(
        .WORD_LENGTH (32),
        .ADDR_LENGTH (5),
        .LOAD_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_result (alu_result),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .qa1        (qa1),
        .qa2        (qa2),
        .hz1        (hz1),
        .hz2        (hz2),
        .perf_stall (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending loads as an ordered queue plus the last issued write.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t            mq[$];
    logic            m_we;
    logic [4:0]      m_wa;
    logic [31:0]     m_wd;
    longint unsigned m_stall;

    function automatic logic [31:0] exp_perf();
`ifdef WB_PERF_EN
        return m_stall[31:0];
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic hz_ref(input logic [4:0] qa);
        if (qa == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == qa) return 1'b1;
        return m_we && (m_wa == qa);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_wa    = '0;
        m_wd    = '0;
        m_stall = 0;
    endtask

    // One clock: check registered outputs, drive inputs, check combinational outputs, advance model.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                        input logic [4:0] q1, input logic [4:0] q2);
        ent_t        e;
        bit          full;
        bit          wrote;
        logic [4:0]  wrd;
        logic [31:0] wdd;
        check("we3", we3, m_we);
        if (m_we) begin
            check("wa3", wa3, m_wa);
            check("wd3", wd3, m_wd);
        end
        check("perf_stall", perf_stall, exp_perf());
        alu_valid = av; alu_rd = ard; alu_result = ad;
        ld_valid = lv;  ld_rd = lrd;  ld_data = ldd;
        qa1 = q1; qa2 = q2;
        #1;
        full = (mq.size() == DEPTH);
        check("ld_ready", ld_ready, !full);
        check("alu_ready", alu_ready, !full);
        check("hz1", hz1, hz_ref(q1));
        check("hz2", hz2, hz_ref(q2));
        wrote = 1'b0; wrd = '0; wdd = '0;
        if (full || (!av && mq.size() != 0)) begin
            e = mq.pop_front();
            wrote = 1'b1; wrd = e.rd; wdd = e.data;
        end else if (av) begin
            wrote = 1'b1; wrd = ard; wdd = ad;
        end
        if (lv && !full) begin
            e.rd = lrd; e.data = ldd;
            mq.push_back(e);
        end
        if (av && full && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_we = wrote && (wrd != 5'd0);
        if (wrote) begin
            m_wa = wrd;
            m_wd = wdd;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_result = 0;
        ld_valid = 0;  ld_rd = 0;  ld_data = 0;
        qa1 = 0; qa2 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_we3", we3, 0);
        check("rst_wa3", wa3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_ld_ready", ld_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);

        // ALU write with empty FIFO lands one cycle later
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5, 0);
        check("t2_we3", we3, 1);
        check("t2_wa3", wa3, 5);
        check("t2_wd3", wd3, 32'hDEADBEEF);
        idle(2);

        // Load held behind continuous ALU traffic, visible as a hazard
        step(1, 5'd3, 32'h1111_0003, 1, 5'd7, 32'h7777_0007, 5'd7, 5'd3);
        step(1, 5'd4, 32'h1111_0004, 0, 0, 0, 5'd7, 5'd4);
        check("t3_hz_held", hz1, 1);
        step(1, 5'd6, 32'h1111_0006, 0, 0, 0, 5'd7, 5'd6);
        step(0, 0, 0, 0, 0, 0, 5'd7, 0);
        check("t3_we3", we3, 1);
        check("t3_wa3", wa3, 7);
        check("t3_wd3", wd3, 32'h7777_0007);
        idle(2);

        // Fill FIFO under ALU pressure: stalls and in-order drain
        for (int unsigned i = 0; i < 6; i++)
            step(1, 5'(i + 1), 32'hA000_0000 + i, 1, 5'(i + 10), 32'hB000_0000 + i, 5'd10, 5'd11);
        idle(4);
        check("t4_perf", perf_stall, exp_perf());

        // rd==0 from both sources: consumed, never written, never a hazard
        step(1, 0, 32'hCAFE_0000, 1, 0, 32'hCAFE_0001, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_we3", we3, 0);
        check("t5_hz0", hz1, 0);
        idle(2);

        // Steady push+pop at count 1 across pointer wrap
        step(0, 0, 0, 1, 5'd20, 32'hC000_0000, 0, 0);
        for (int unsigned i = 0; i < 10; i++)
            step(0, 0, 0, 1, 5'(21 + i), 32'hC000_0001 + i, 5'(21 + i), 5'(20 + i));
        idle(3);

        // Reset mid-stream with two loads queued
        step(1, 5'd1, 32'hD000_0001, 1, 5'd30, 32'hE000_0000, 0, 0);
        step(1, 5'd2, 32'hD000_0002, 1, 5'd31, 32'hE000_0001, 0, 0);
        alu_valid = 0; ld_valid = 0;
        reset_n = 1'b0;
        #1;
        check("t1_we3", we3, 0);
        check("t1_wa3", wa3, 0);
        check("t1_wd3", wd3, 0);
        check("t1_ld_ready", ld_ready, 1);
        check("t1_alu_ready", alu_ready, 1);
        check("t1_perf", perf_stall, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        idle(4);

        // Randomised traffic
        for (int unsigned i = 0; i < 600; i++) begin
            step(($urandom_range(99, 0) < 65), 5'($urandom_range(7, 0)), $urandom,
                 ($urandom_range(99, 0) < 50), 5'($urandom_range(7, 0)), $urandom,
                 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
